// File: rtl/tproj_pkg.sv
// Shared constants and header-word helpers for the BX-paged projection buffer.
// Default widths match the tracklet projection word layout.
package tproj_pkg;

    localparam int DEF_DATA_W = 55;
    localparam int DEF_BX_W   = 3;
    localparam int DEF_ADDR_W = 6;

    localparam logic [3:0] HDR_MARKER = 4'hF;

    function automatic logic is_header(input logic [DEF_DATA_W-1:0] word);
        return word[DEF_DATA_W-1 -: 4] == HDR_MARKER;
    endfunction

    function automatic logic [DEF_BX_W-1:0] hdr_bx(input logic [DEF_DATA_W-1:0] word);
        return word[DEF_DATA_W-5 -: DEF_BX_W];
    endfunction

endpackage

// File: rtl/tproj_sdp_ram.sv
// Simple dual-port RAM: one write, one read, read-first, registered output.
// No reset on the array or output so it maps onto block RAM.
module tproj_sdp_ram #(
    parameter int DW = 55,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tproj_bx_paged_memory.sv
// BX-paged projection buffer: header words open a page, data words fill it,
// and an addressed read port returns entries with a fixed two-cycle latency.
module tproj_bx_paged_memory
    import tproj_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int BX_W   = DEF_BX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              proc_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              rd_en,
    input  logic [BX_W-1:0]   rd_bx,
    input  logic [ADDR_W-1:0] rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   rd_nentries,
    output logic [BX_W-1:0]   cur_bx,
    output logic              overflow
);

    localparam int NPAGE      = 2**BX_W;
    localparam int PAGE_DEPTH = 2**ADDR_W;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int RAM_AW     = BX_W + ADDR_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PAGE_DEPTH);

    logic [3:0]      in_marker;
    logic [BX_W-1:0] in_bx;
    logic            is_hdr;
    logic            is_dat;
    logic            page_full;
    logic            wr_en;

    logic              page_open_q, page_open_d;
    logic [BX_W-1:0]   cur_bx_q,    cur_bx_d;
    logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic              overflow_q,  overflow_d;
    logic [CNT_W-1:0]  count_q [NPAGE];
    logic [CNT_W-1:0]  count_d [NPAGE];

    assign in_marker = in_data[DATA_W-1 -: 4];
    assign in_bx     = in_data[DATA_W-5 -: BX_W];
    assign is_hdr    = in_valid && (in_marker == HDR_MARKER);
    assign is_dat    = in_valid && !is_hdr && page_open_q;
    assign page_full = (count_q[cur_bx_q] == CNT_FULL);

    always_comb begin
        page_open_d = page_open_q;
        cur_bx_d    = cur_bx_q;
        wr_ptr_d    = wr_ptr_q;
        overflow_d  = overflow_q;
        count_d     = count_q;
        wr_en       = 1'b0;
        if (is_hdr) begin
            cur_bx_d       = in_bx;
            count_d[in_bx] = '0;
            wr_ptr_d       = '0;
            overflow_d     = 1'b0;
            page_open_d    = 1'b1;
        end else if (is_dat) begin
            if (!page_full) begin
                wr_en             = 1'b1;
                wr_ptr_d          = wr_ptr_q + ADDR_W'(1);
                count_d[cur_bx_q] = count_q[cur_bx_q] + CNT_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Read side: hit is judged on the count before this cycle's write,
    // so an entry being written right now is never reported valid.
    logic             hit_d;
    logic [CNT_W-1:0] nent_d;
    logic             hit_q1;
    logic [CNT_W-1:0] nent_q1;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_nent_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] ram_rdata;

    assign nent_d = count_q[rd_bx];
    assign hit_d  = rd_en && (CNT_W'(rd_idx) < nent_d);

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            page_open_q <= 1'b0;
            cur_bx_q    <= '0;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            count_q     <= '{default: '0};
            hit_q1      <= 1'b0;
            nent_q1     <= '0;
            rd_valid_q  <= 1'b0;
            rd_nent_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            page_open_q <= page_open_d;
            cur_bx_q    <= cur_bx_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            hit_q1      <= hit_d;
            nent_q1     <= nent_d;
            rd_valid_q  <= hit_q1;
            rd_nent_q   <= nent_q1;
            rd_data_q   <= ram_rdata;
        end
    end

    tproj_sdp_ram #(
        .DW (DATA_W),
        .AW (RAM_AW)
    ) u_ram (
        .clk_i   (proc_clk),
        .we_i    (wr_en && !reset),
        .waddr_i ({cur_bx_q, wr_ptr_q}),
        .wdata_i (in_data),
        .raddr_i ({rd_bx, rd_idx}),
        .rdata_o (ram_rdata)
    );

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign rd_nentries = rd_nent_q;
    assign cur_bx      = cur_bx_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_tproj_bx_paged_memory.sv
// Bench for the BX-paged projection buffer: directed tables, corner sequences
// and a randomized run checked against a page-level reference model.
module tb_tproj_bx_paged_memory;
    import tproj_pkg::*;

    localparam int DW = 55;

    logic          proc_clk = 1'b0;
    logic          reset    = 1'b1;
    logic [DW-1:0] in_data  = '0;
    logic          in_valid = 1'b0;
    logic          rd_en    = 1'b0;
    logic [2:0]    rd_bx    = '0;
    logic [5:0]    rd_idx   = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [6:0]    rd_nentries;
    logic [2:0]    cur_bx;
    logic          overflow;

    tproj_bx_paged_memory dut (
        .proc_clk    (proc_clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .rd_en       (rd_en),
        .rd_bx       (rd_bx),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_nentries (rd_nentries),
        .cur_bx      (cur_bx),
        .overflow    (overflow)
    );

    always #5 proc_clk = ~proc_clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_mem [8][64];
    int            m_cnt [8];
    int            m_cur;
    bit            m_open;
    bit            m_ovf;

    typedef struct {
        bit            rd;
        bit            v;
        logic [DW-1:0] d;
        int            n;
    } pe_t;

    pe_t p1, p2, np;

    typedef struct {
        int            bx;
        int            idx;
        bit            v;
        logic [DW-1:0] d;
        int            n;
    } rvec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 8; p++) m_cnt[p] = 0;
        m_cur  = 0;
        m_open = 0;
        m_ovf  = 0;
        p1     = '{default: 0};
        p2     = '{default: 0};
    endtask

    task automatic model_apply(input bit iv, input logic [DW-1:0] w);
        if (!iv) return;
        if (w[DW-1 -: 4] == 4'hF) begin
            m_cur        = int'(w[DW-5 -: 3]);
            m_cnt[m_cur] = 0;
            m_ovf        = 0;
            m_open       = 1;
        end else if (m_open) begin
            if (m_cnt[m_cur] < 64) begin
                m_mem[m_cur][m_cnt[m_cur]] = w;
                m_cnt[m_cur]++;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic cyc(input bit iv, input logic [DW-1:0] w,
                       input bit re, input int rb, input int ri);
        in_valid = iv;
        in_data  = w;
        rd_en    = re;
        rd_bx    = 3'(rb);
        rd_idx   = 6'(ri);
        np.rd = re;
        np.v  = re && (ri < m_cnt[rb]);
        np.d  = m_mem[rb][ri];
        np.n  = m_cnt[rb];
        @(posedge proc_clk);
        if (reset) begin
            model_reset();
        end else begin
            model_apply(iv, w);
            p2 = p1;
            p1 = np;
        end
        #1;
        chk("cur_bx", 64'(cur_bx), 64'(m_cur));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("rd_valid", 64'(rd_valid), 64'(p2.v));
        if (p2.v) chk("rd_data", 64'(rd_data), 64'(p2.d));
        if (p2.rd) chk("rd_nentries", 64'(rd_nentries), 64'(p2.n));
    endtask

    task automatic idle();
        cyc(0, '0, 0, 0, 0);
    endtask

    function automatic logic [DW-1:0] hdr_word(input int bx);
        logic [47:0] r;
        r = 48'({$urandom(), $urandom()});
        return {4'hF, 3'(bx), r};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        w = DW'({$urandom(), $urandom()});
        if (is_header(w)) w[DW-1] = 1'b0;
        return w;
    endfunction

    task automatic hdr(input int bx);
        cyc(1, hdr_word(bx), 0, 0, 0);
    endtask

    task automatic dat(input logic [DW-1:0] w);
        cyc(1, w, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    // Must be entered after a cycle without a read request.
    task automatic rd_check(input string name, input int bx, input int idx,
                            input bit ev, input int en, input logic [DW-1:0] ed);
        cyc(0, '0, 1, bx, idx);
        chk({name, "_lat1"}, 64'(rd_valid), 64'(0));
        idle();
        chk({name, "_v"}, 64'(rd_valid), 64'(ev));
        chk({name, "_n"}, 64'(rd_nentries), 64'(en));
        if (ev) chk({name, "_d"}, 64'(rd_data), 64'(ed));
    endtask

    logic [DW-1:0] d0, d1, d2, w5, nw0, nw1;
    rvec_t tbl [4];

    initial begin
        model_reset();

        // 1: basic page fill and read-back
        reset = 1'b1;
        idle();
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        chk("rst_nentries", 64'(rd_nentries), 64'(0));
        chk("rst_valid", 64'(rd_valid), 64'(0));
        reset = 1'b0;
        d0 = 55'h01_2345_6789_ABCD;
        d1 = 55'h12_3456_789A_BCDE;
        d2 = 55'h23_4567_89AB_CDEF;
        tbl[0] = '{bx: 2, idx: 0, v: 1, d: d0, n: 3};
        tbl[1] = '{bx: 2, idx: 1, v: 1, d: d1, n: 3};
        tbl[2] = '{bx: 2, idx: 2, v: 1, d: d2, n: 3};
        tbl[3] = '{bx: 2, idx: 3, v: 0, d: '0, n: 3};
        hdr(2);
        chk("t1_cur_bx", 64'(cur_bx), 64'(2));
        dat(d0);
        dat(d1);
        dat(d2);
        for (int i = 0; i < 4; i++) begin
            rd_check($sformatf("t1_rd%0d", i), tbl[i].bx, tbl[i].idx,
                     tbl[i].v, tbl[i].n, tbl[i].d);
        end

        // 2: overflow at 65th word, cleared by next header
        hdr(5);
        for (int i = 1; i <= 70; i++) begin
            dat(rand_word());
            if (i == 64) chk("t2_ovf64", 64'(overflow), 64'(0));
            if (i == 65) chk("t2_ovf65", 64'(overflow), 64'(1));
        end
        chk("t2_ovf70", 64'(overflow), 64'(1));
        rd_check("t2_last", 5, 63, 1, 64, m_mem[5][63]);
        rd_check("t2_first", 5, 0, 1, 64, m_mem[5][0]);
        hdr(6);
        chk("t2_ovf_clr", 64'(overflow), 64'(0));

        // 3: page reuse after a full BX cycle
        hdr(1);
        for (int i = 0; i < 4; i++) dat(rand_word());
        for (int b = 2; b < 10; b++) hdr(b % 8);
        nw0 = rand_word();
        nw1 = rand_word();
        dat(nw0);
        dat(nw1);
        rd_check("t3_rd0", 1, 0, 1, 2, nw0);
        rd_check("t3_rd1", 1, 1, 1, 2, nw1);
        rd_check("t3_rd2", 1, 2, 0, 2, '0);

        // 4: read of the entry being written this cycle
        hdr(3);
        for (int i = 0; i < 4; i++) dat(rand_word());
        w5 = rand_word();
        cyc(1, w5, 1, 3, 4);
        cyc(0, '0, 1, 3, 4);
        chk("t4_collide_v", 64'(rd_valid), 64'(0));
        idle();
        chk("t4_next_v", 64'(rd_valid), 64'(1));
        chk("t4_next_d", 64'(rd_data), 64'(w5));
        chk("t4_next_n", 64'(rd_nentries), 64'(5));

        // 5: data before any header is dropped silently
        do_reset();
        for (int i = 0; i < 5; i++) dat(rand_word());
        chk("t5_ovf", 64'(overflow), 64'(0));
        for (int p = 0; p < 8; p++) begin
            rd_check($sformatf("t5_pg%0d", p), p, 0, 0, 0, '0);
        end

        // 6: reset with reads in flight
        hdr(2);
        for (int i = 0; i < 3; i++) dat(rand_word());
        cyc(0, '0, 1, 2, 0);
        cyc(0, '0, 1, 2, 1);
        reset = 1'b1;
        cyc(1, rand_word(), 1, 2, 2);
        chk("t6_flush0", 64'(rd_valid), 64'(0));
        reset = 1'b0;
        for (int i = 1; i < 4; i++) begin
            idle();
            chk($sformatf("t6_flush%0d", i), 64'(rd_valid), 64'(0));
        end
        chk("t6_cur_bx", 64'(cur_bx), 64'(0));
        for (int p = 0; p < 8; p++) begin
            rd_check($sformatf("t6_pg%0d", p), p, 0, 0, 0, '0);
        end

        // Randomized traffic against the page model
        for (int i = 0; i < 3000; i++) begin
            int r, rb, ri;
            bit re, iv;
            logic [DW-1:0] w;
            r  = int'($urandom_range(0, 999));
            re = bit'($urandom_range(0, 1));
            rb = int'($urandom_range(0, 7));
            ri = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                             : int'($urandom_range(0, 7));
            iv = 1;
            if (r < 30)       w = hdr_word(int'($urandom_range(0, 7)));
            else if (r < 750) w = rand_word();
            else begin
                iv = 0;
                w  = rand_word();
            end
            reset = (r >= 995);
            cyc(iv, w, re, rb, ri);
        end
        reset = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
